// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and helpers for the program-load/run controller.
// Holds the controller state enum, the default halt word and the
// counter saturation limit helper.
package cpu_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HOLD,
    ST_RUN,
    ST_DONE,
    ST_TIMEOUT
  } runState_t;

  // Scan value that marks the end of a program run
  localparam logic [31:0] HALT_INSTR_DEFAULT = 32'h0000_0000;

  // Largest value a counter of the given width can hold
  function automatic logic [63:0] cntMax(input int unsigned width);
    return (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Host load stream plus instruction-memory write port of cpu_run_ctrl.
// slave  : the controller (accepts words, drives the memory write port)
// master : the host/memory side
interface cpu_run_ctrl_if #(
  parameter int ADDR_W  = 10,
  parameter int INSTR_W = 32
);

  logic               i_Load_Valid;
  logic               o_Load_Ready;
  logic [INSTR_W-1:0] i_Load_Instr;
  logic               i_Load_Last;
  logic [ADDR_W-1:0]  o_InstrMEM_Write_Addr;
  logic [INSTR_W-1:0] o_InstrMEM_Write_Instr;
  logic               o_InstrMEM_MemWrite;

  modport slave (
    input  i_Load_Valid, i_Load_Instr, i_Load_Last,
    output o_Load_Ready, o_InstrMEM_Write_Addr, o_InstrMEM_Write_Instr,
           o_InstrMEM_MemWrite
  );

  modport master (
    output i_Load_Valid, i_Load_Instr, i_Load_Last,
    input  o_Load_Ready, o_InstrMEM_Write_Addr, o_InstrMEM_Write_Instr,
           o_InstrMEM_MemWrite
  );

endinterface

// File: rtl/cpu_run_ctrl_sat_counter.sv
// Saturating up-counter used for the run-cycle and side-event counts.
// Synchronous clear has priority over increment; the count sticks at
// its maximum instead of wrapping.
module sat_counter
  import cpu_run_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(cntMax(CNT_W));

  logic [CNT_W-1:0] r_cnt;

  // Clear on a new sequence, otherwise count up until the ceiling
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAX_VAL)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Program-load and run controller for the pipelined RISC-I core.
// Streams a program into instruction memory while the CPU is held in
// reset, releases the CPU after a short hold, then counts run cycles
// until the halt word is scanned, plus NUM_EVT side-event channels.
// Optional feature macro: CPU_RUN_TIMEOUT_EN (adds TIMEOUT_CYC and the
// TIMEOUT state; without it o_Timeout is tied low).
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int INSTR_W  = 32,
  parameter int CNT_W    = 32,
  parameter int NUM_EVT  = 2,
  parameter int RST_HOLD = 2,
  parameter logic [INSTR_W-1:0] HALT_INSTR = INSTR_W'(HALT_INSTR_DEFAULT)
`ifdef CPU_RUN_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 100000
`endif
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic                     i_Start,
  cpu_run_ctrl_if.slave            loadBus,
  output logic                     o_CPU_RSTN,
  input  logic [INSTR_W-1:0]       i_scan_instr,
  input  logic [NUM_EVT-1:0]       i_Evt,
  output logic [CNT_W-1:0]         o_Cycles,
  output logic [NUM_EVT*CNT_W-1:0] o_Evt_Cnt,
  output logic                     o_Busy,
  output logic                     o_Done,
  output logic                     o_Timeout
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  runState_t          r_state;
  logic [ADDR_W-1:0]  r_loadAddr;
  logic [ADDR_W-1:0]  r_wrAddr;
  logic [INSTR_W-1:0] r_wrInstr;
  logic               r_memWrite;
  logic               r_loadReady;
  logic               r_cpuRstn;
  logic               r_done;
  logic [HOLD_W-1:0]  r_holdCnt;

  logic w_start;
  logic w_xfer;
  logic w_run;
  logic w_halt;
  logic w_toHit;
  logic w_cycInc;

  assign w_start  = i_Start && (r_state inside {ST_IDLE, ST_DONE, ST_TIMEOUT});
  assign w_xfer   = (r_state == ST_LOAD) && loadBus.i_Load_Valid && r_loadReady;
  assign w_run    = (r_state == ST_RUN);
  assign w_halt   = w_run && (i_scan_instr == HALT_INSTR);

`ifdef CPU_RUN_TIMEOUT_EN
  // A limit above the counter ceiling can never be reached
  localparam bit TO_REACH = (64'(TIMEOUT_CYC) <= cntMax(CNT_W));
  logic r_timeout;
  assign w_toHit   = TO_REACH && w_run && !w_halt &&
                     (o_Cycles == CNT_W'(TIMEOUT_CYC));
  assign o_Timeout = r_timeout;
`else
  assign w_toHit   = 1'b0;
  assign o_Timeout = 1'b0;
`endif

  // The cycle count stops on the halt cycle and on the timeout cycle
  assign w_cycInc = w_run && !w_halt && !w_toHit;

  // Sequence controller: load handshake, reset hold, run and end states
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_state     <= ST_IDLE;
      r_loadAddr  <= '0;
      r_wrAddr    <= '0;
      r_wrInstr   <= '0;
      r_memWrite  <= 1'b0;
      r_loadReady <= 1'b0;
      r_cpuRstn   <= 1'b0;
      r_done      <= 1'b0;
      r_holdCnt   <= '0;
`ifdef CPU_RUN_TIMEOUT_EN
      r_timeout   <= 1'b0;
`endif
    end else begin
      r_memWrite <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_TIMEOUT: begin
          r_cpuRstn <= 1'b0;
          if (w_start) begin
            r_state     <= ST_LOAD;
            r_loadAddr  <= '0;
            r_loadReady <= 1'b1;
            r_done      <= 1'b0;
`ifdef CPU_RUN_TIMEOUT_EN
            r_timeout   <= 1'b0;
`endif
          end
        end
        ST_LOAD: begin
          if (w_xfer) begin
            r_memWrite <= 1'b1;
            r_wrAddr   <= r_loadAddr;
            r_wrInstr  <= loadBus.i_Load_Instr;
            if (loadBus.i_Load_Last || (r_loadAddr == LAST_ADDR)) begin
              r_state     <= ST_HOLD;
              r_loadReady <= 1'b0;
              r_holdCnt   <= '0;
            end else begin
              r_loadAddr <= r_loadAddr + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (r_holdCnt == HOLD_W'(RST_HOLD - 1)) begin
            r_cpuRstn <= 1'b1;
            r_state   <= ST_RUN;
          end else begin
            r_holdCnt <= r_holdCnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (w_halt) begin
            r_state   <= ST_DONE;
            r_done    <= 1'b1;
            r_cpuRstn <= 1'b0;
          end
`ifdef CPU_RUN_TIMEOUT_EN
          else if (w_toHit) begin
            r_state   <= ST_TIMEOUT;
            r_timeout <= 1'b1;
            r_done    <= 1'b0;
            r_cpuRstn <= 1'b0;
          end
`endif
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign loadBus.o_Load_Ready           = r_loadReady;
  assign loadBus.o_InstrMEM_Write_Addr  = r_wrAddr;
  assign loadBus.o_InstrMEM_Write_Instr = r_wrInstr;
  assign loadBus.o_InstrMEM_MemWrite    = r_memWrite;
  assign o_CPU_RSTN = r_cpuRstn;
  assign o_Done     = r_done;
  assign o_Busy     = r_state inside {ST_LOAD, ST_HOLD, ST_RUN};

  sat_counter #(.CNT_W(CNT_W)) u_cycCnt (
    .i_clk (i_CLK),
    .i_rst (i_RST),
    .i_clr (w_start),
    .i_inc (w_cycInc),
    .o_cnt (o_Cycles)
  );

  for (genvar k = 0; k < NUM_EVT; k++) begin : g_evt
    sat_counter #(.CNT_W(CNT_W)) u_evtCnt (
      .i_clk (i_CLK),
      .i_rst (i_RST),
      .i_clr (w_start),
      .i_inc (w_run && i_Evt[k]),
      .o_cnt (o_Evt_Cnt[k*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Testbench for cpu_run_ctrl. Two instances share one stimulus stream:
// instance A has 32-bit counters, instance B 4-bit counters so that
// saturation shows up on ordinary run lengths. Both use an 8-word memory.
// Timeout checks are compiled only when CPU_RUN_TIMEOUT_EN is defined.
module tb_cpu_run_ctrl;

  localparam int ADDR_W   = 3;
  localparam int INSTR_W  = 32;
  localparam int NUM_EVT  = 2;
  localparam int RST_HOLD = 2;
  localparam int CNT_A    = 32;
  localparam int CNT_B    = 4;
  localparam int DEPTH    = 1 << ADDR_W;
  localparam int SAT_B    = (1 << CNT_B) - 1;
`ifdef CPU_RUN_TIMEOUT_EN
  localparam int TO_CYC   = 50;
`endif

  logic clock;
  logic reset;
  logic start;
  logic valid;
  logic last;
  logic [INSTR_W-1:0] instr;
  logic [INSTR_W-1:0] scan;
  logic [NUM_EVT-1:0] evt;

  logic rstnA, busyA, doneA, toA;
  logic rstnB, busyB, doneB, toB;
  logic [CNT_A-1:0] cycA;
  logic [CNT_B-1:0] cycB;
  logic [NUM_EVT*CNT_A-1:0] evtA;
  logic [NUM_EVT*CNT_B-1:0] evtB;

  int total = 0;
  int bad   = 0;
  int expCyc;
  int expEvt [NUM_EVT];
  int acc;

  cpu_run_ctrl_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) busA ();
  cpu_run_ctrl_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) busB ();

  assign busA.i_Load_Valid = valid;
  assign busA.i_Load_Instr = instr;
  assign busA.i_Load_Last  = last;
  assign busB.i_Load_Valid = valid;
  assign busB.i_Load_Instr = instr;
  assign busB.i_Load_Last  = last;

  cpu_run_ctrl #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .CNT_W(CNT_A),
    .NUM_EVT(NUM_EVT), .RST_HOLD(RST_HOLD), .HALT_INSTR(32'h0)
`ifdef CPU_RUN_TIMEOUT_EN
    , .TIMEOUT_CYC(TO_CYC)
`endif
  ) u_dutA (
    .i_CLK(clock), .i_RST(reset), .i_Start(start), .loadBus(busA.slave),
    .o_CPU_RSTN(rstnA), .i_scan_instr(scan), .i_Evt(evt),
    .o_Cycles(cycA), .o_Evt_Cnt(evtA), .o_Busy(busyA),
    .o_Done(doneA), .o_Timeout(toA)
  );

  cpu_run_ctrl #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .CNT_W(CNT_B),
    .NUM_EVT(NUM_EVT), .RST_HOLD(RST_HOLD), .HALT_INSTR(32'h0)
`ifdef CPU_RUN_TIMEOUT_EN
    , .TIMEOUT_CYC(TO_CYC)
`endif
  ) u_dutB (
    .i_CLK(clock), .i_RST(reset), .i_Start(start), .loadBus(busB.slave),
    .o_CPU_RSTN(rstnB), .i_scan_instr(scan), .i_Evt(evt),
    .o_Cycles(cycB), .o_Evt_Cnt(evtB), .o_Busy(busyB),
    .o_Done(doneB), .o_Timeout(toB)
  );

  // Free-running clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic int satB(input int x);
    return (x > SAT_B) ? SAT_B : x;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic v,
                               input logic [INSTR_W-1:0] w, input logic l);
    start = s;
    valid = v;
    instr = w;
    last  = l;
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_cycA"}, 64'(cycA), 64'(expCyc));
    checkOutput({tag, "_cycB"}, 64'(cycB), 64'(satB(expCyc)));
    for (int k = 0; k < NUM_EVT; k++) begin
      checkOutput({tag, "_evtA"}, 64'(evtA[k*CNT_A +: CNT_A]), 64'(expEvt[k]));
      checkOutput({tag, "_evtB"}, 64'(evtB[k*CNT_B +: CNT_B]), 64'(satB(expEvt[k])));
    end
  endtask

  // Start a sequence and stream nWords words; the model predicts which
  // cycles transfer, where each word lands and when the CPU is released.
  task automatic loadProgram(input int nWords, input bit throttle,
                             input bit markLast, output int accepted);
    bit mReady;
    bit ended;
    bit v;
    bit x;
    bit l;
    int mAddr;
    int idx;
    int cyc;
    logic [INSTR_W-1:0] w;
    accepted = 0;
    mAddr = 0;
    idx = 0;
    cyc = 0;
    ended = 0;
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    @(negedge clock);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("busy_after_start", 64'(busyA), 64'(1));
    mReady = 1;
    while (idx < nWords && !ended && cyc < 4 * nWords + 8) begin
      v = !throttle || (cyc % 2 == 0);
      w = $urandom;
      l = markLast && (idx == nWords - 1);
      applyStimulus(1'b0, v, w, l);
      checkOutput("load_ready_A", 64'(busA.o_Load_Ready), 64'(mReady));
      checkOutput("load_ready_B", 64'(busB.o_Load_Ready), 64'(mReady));
      x = v && mReady;
      @(negedge clock);
      cyc++;
      checkOutput("mem_write_A", 64'(busA.o_InstrMEM_MemWrite), 64'(x));
      checkOutput("mem_write_B", 64'(busB.o_InstrMEM_MemWrite), 64'(x));
      if (x) begin
        checkOutput("wr_addr_A", 64'(busA.o_InstrMEM_Write_Addr), 64'(mAddr));
        checkOutput("wr_data_A", 64'(busA.o_InstrMEM_Write_Instr), 64'(w));
        checkOutput("wr_addr_B", 64'(busB.o_InstrMEM_Write_Addr), 64'(mAddr));
        accepted++;
        idx++;
        if (l || mAddr == DEPTH - 1) begin
          mReady = 0;
          ended = 1;
        end else begin
          mAddr++;
        end
      end
    end
    // Any word left over stays offered to show it is never taken
    applyStimulus(1'b0, idx < nWords, $urandom, 1'b0);
    if (ended) begin
      checkOutput("rstn_after_last", 64'(rstnA), 64'(0));
      for (int h = 1; h <= RST_HOLD; h++) begin
        checkOutput("hold_ready", 64'(busA.o_Load_Ready), 64'(0));
        @(negedge clock);
        checkOutput("hold_no_write", 64'(busA.o_InstrMEM_MemWrite), 64'(0));
        checkOutput("rstn_rise_A", 64'(rstnA), 64'(h == RST_HOLD));
        checkOutput("rstn_rise_B", 64'(rstnB), 64'(h == RST_HOLD));
      end
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
  endtask

  // Drive nCycles non-halt scan words then the halt word; directed mode
  // raises event 1 on the first ten cycles only, otherwise events are random.
  task automatic runProgram(input int nCycles, input bit directed);
    expCyc = 0;
    for (int k = 0; k < NUM_EVT; k++) expEvt[k] = 0;
    for (int i = 0; i < nCycles; i++) begin
      scan = $urandom | 32'h1;
      evt  = directed ? {(i < 10), 1'b0} : NUM_EVT'($urandom);
      expCyc++;
      for (int k = 0; k < NUM_EVT; k++) expEvt[k] += int'(evt[k]);
      checkOutput("run_rstn", 64'(rstnA), 64'(1));
      @(negedge clock);
    end
    scan = 32'h0;
    evt  = directed ? '0 : NUM_EVT'($urandom);
    for (int k = 0; k < NUM_EVT; k++) expEvt[k] += int'(evt[k]);
    @(negedge clock);
    scan = 32'h13;
    checkOutput("done_A", 64'(doneA), 64'(1));
    checkOutput("done_B", 64'(doneB), 64'(1));
    checkOutput("halt_rstn_A", 64'(rstnA), 64'(0));
    checkOutput("halt_busy_A", 64'(busyA), 64'(0));
    checkOutput("halt_timeout_A", 64'(toA), 64'(0));
    checkCounters("halt");
    for (int i = 0; i < 3; i++) begin
      evt = NUM_EVT'($urandom);
      @(negedge clock);
    end
    evt = '0;
    checkCounters("done_hold");
  endtask

  // Directed sequence
  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    scan = 32'h13;
    evt  = '0;
    repeat (2) @(negedge clock);
    checkOutput("rst_rstn", 64'(rstnA), 64'(0));
    checkOutput("rst_write", 64'(busA.o_InstrMEM_MemWrite), 64'(0));
    checkOutput("rst_ready", 64'(busA.o_Load_Ready), 64'(0));
    checkOutput("rst_busy", 64'(busyA), 64'(0));
    checkOutput("rst_done", 64'(doneA), 64'(0));
    checkOutput("rst_timeout", 64'(toA), 64'(0));
    checkOutput("rst_cycles", 64'(cycA), 64'(0));
    reset = 1'b0;
    @(negedge clock);

    $display("[TB] back-to-back load and 37-cycle run");
    loadProgram(5, 1'b0, 1'b1, acc);
    checkOutput("accepted_5", 64'(acc), 64'(5));
    runProgram(37, 1'b1);

    $display("[TB] reset in the middle of a load");
    loadProgram(3, 1'b0, 1'b0, acc);
    reset = 1'b1;
    #1;
    checkOutput("midrst_write", 64'(busA.o_InstrMEM_MemWrite), 64'(0));
    checkOutput("midrst_ready", 64'(busA.o_Load_Ready), 64'(0));
    checkOutput("midrst_busy", 64'(busyA), 64'(0));
    @(negedge clock);
    checkOutput("midrst_rstn", 64'(rstnA), 64'(0));
    checkOutput("midrst_busy2", 64'(busyA), 64'(0));
    reset = 1'b0;
    @(negedge clock);

    $display("[TB] throttled load and 20-cycle run");
    loadProgram(4, 1'b1, 1'b1, acc);
    checkOutput("accepted_4", 64'(acc), 64'(4));
    runProgram(20, 1'b0);

    $display("[TB] random loads and runs");
    for (int r = 0; r < 3; r++) begin
      loadProgram(int'($urandom_range(1, DEPTH)), 1'($urandom), 1'b1, acc);
      runProgram(int'($urandom_range(5, 40)), 1'b0);
    end

    $display("[TB] memory overflow");
    loadProgram(DEPTH + 1, 1'b0, 1'b0, acc);
    checkOutput("accepted_overflow", 64'(acc), 64'(DEPTH));
    runProgram(6, 1'b0);

`ifdef CPU_RUN_TIMEOUT_EN
    $display("[TB] halt on the timeout cycle, then timeout");
    loadProgram(2, 1'b0, 1'b1, acc);
    runProgram(TO_CYC, 1'b0);
    loadProgram(2, 1'b0, 1'b1, acc);
    for (int i = 0; i < TO_CYC; i++) begin
      scan = $urandom | 32'h1;
      @(negedge clock);
    end
    checkOutput("pre_timeout_flag", 64'(toA), 64'(0));
    checkOutput("pre_timeout_cycles", 64'(cycA), 64'(TO_CYC));
    scan = 32'h5;
    @(negedge clock);
    scan = 32'h13;
    checkOutput("timeout_flag", 64'(toA), 64'(1));
    checkOutput("timeout_cycles", 64'(cycA), 64'(TO_CYC));
    checkOutput("timeout_done", 64'(doneA), 64'(0));
    checkOutput("timeout_rstn", 64'(rstnA), 64'(0));
    checkOutput("timeout_busy", 64'(busyA), 64'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
